// File: rtl/store_buffer.sv
// store_buffer: in-order store queue that formats sub-word stores, drains them to memory and flags load conflicts
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     StoreValidM,
   input  logic [1:0]               StoreTypeM,
   input  logic [31:0]              AddrM,
   input  logic [31:0]              WriteDataM,
   input  logic                     LoadValidM,
   input  logic                     MemReqReady,
   output logic                     MemReqValid,
   output logic [31:0]              MemReqAddr,
   output logic [31:0]              MemReqData,
   output logic [3:0]               MemReqStrb,
   output logic                     StallM2H,
   output logic                     MisalignM2H,
   output logic [$clog2(DEPTH):0]   CountM
);
   localparam int AW = $clog2(DEPTH);

   logic [29:0]      addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [3:0]       strb_q [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [31:0]      fdata;
   logic [3:0]       fstrb;
   logic             sb, sh, sw, mis, full, conflict, enq, deq;

   // lane-align the store and decide whether it may enter the queue
   always_comb begin
      sb       = StoreTypeM == 2'b00;
      sh       = StoreTypeM == 2'b01;
      sw       = StoreTypeM == 2'b10;
      fdata    = sb ? {4{WriteDataM[7:0]}} : sh ? {2{WriteDataM[15:0]}} : WriteDataM;
      fstrb    = sb ? 4'b0001 << AddrM[1:0] : sh ? (AddrM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      mis      = (sh & AddrM[0]) | (sw & |AddrM[1:0]) | (&StoreTypeM);
      full     = CountM == (AW+1)'(DEPTH);
      conflict = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (vld[i] && addr_q[i] == AddrM[31:2]) conflict = 1'b1;
      conflict    = conflict & LoadValidM;
      StallM2H    = (StoreValidM & full) | conflict;
      enq         = StoreValidM & ~mis & ~StallM2H;
      MemReqValid = CountM != '0;
      deq         = MemReqValid & MemReqReady;
      MemReqAddr  = MemReqValid ? {addr_q[rd_ptr], 2'b00} : 32'h0;
      MemReqData  = MemReqValid ? data_q[rd_ptr] : 32'h0;
      MemReqStrb  = MemReqValid ? strb_q[rd_ptr] : 4'h0;
   end

   // queue control: pointers, occupancy, per-entry valid and the one-shot misalign flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         CountM      <= '0;
         vld         <= '0;
         MisalignM2H <= 1'b0;
      end else begin
         MisalignM2H <= StoreValidM & mis & ~StallM2H;
         CountM      <= CountM + (AW+1)'(enq) - (AW+1)'(deq);
         if (deq) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + AW'(1);
         end
         if (enq) begin
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= wr_ptr + AW'(1);
         end
      end
   end

   // entry payload; outputs are gated by occupancy so these need no reset
   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[wr_ptr] <= AddrM[31:2];
         data_q[wr_ptr] <= fdata;
         strb_q[wr_ptr] <= fstrb;
      end
   end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed checks of formatting, misalign, full, drain order, load conflict and reset
module tb_store_buffer;
   logic        clk = 0;
   logic        reset = 0;
   logic        StoreValidM = 0;
   logic [1:0]  StoreTypeM = 0;
   logic [31:0] AddrM = 0;
   logic [31:0] WriteDataM = 0;
   logic        LoadValidM = 0;
   logic        MemReqReady = 0;
   logic        MemReqValid;
   logic [31:0] MemReqAddr;
   logic [31:0] MemReqData;
   logic [3:0]  MemReqStrb;
   logic        StallM2H;
   logic        MisalignM2H;
   logic [2:0]  CountM;
   int          tests = 0;
   int          fails = 0;

   store_buffer #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset), .StoreValidM(StoreValidM), .StoreTypeM(StoreTypeM),
      .AddrM(AddrM), .WriteDataM(WriteDataM), .LoadValidM(LoadValidM),
      .MemReqReady(MemReqReady), .MemReqValid(MemReqValid), .MemReqAddr(MemReqAddr),
      .MemReqData(MemReqData), .MemReqStrb(MemReqStrb), .StallM2H(StallM2H),
      .MisalignM2H(MisalignM2H), .CountM(CountM)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic st(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
      StoreValidM = 1;
      StoreTypeM  = t;
      AddrM       = a;
      WriteDataM  = d;
   endtask

   initial begin
      #2;
      chk("rst_valid", MemReqValid, 0);
      chk("rst_count", CountM, 0);
      chk("rst_mis", MisalignM2H, 0);
      chk("rst_addr", MemReqAddr, 0);
      chk("rst_data", MemReqData, 0);
      chk("rst_strb", MemReqStrb, 0);
      tick();
      reset = 1;
      // sb formatting, no bypass, hold while not ready
      st(2'b00, 32'h1003, 32'h0000_00AB);
      chk("sb_nobypass", MemReqValid, 0);
      tick();
      StoreValidM = 0;
      chk("sb_valid", MemReqValid, 1);
      chk("sb_count", CountM, 1);
      chk("sb_addr", MemReqAddr, 32'h1000);
      chk("sb_data", MemReqData, 32'hABAB_ABAB);
      chk("sb_strb", MemReqStrb, 4'b1000);
      tick();
      chk("hold_addr", MemReqAddr, 32'h1000);
      chk("hold_data", MemReqData, 32'hABAB_ABAB);
      MemReqReady = 1;
      tick();
      chk("sb_drained", MemReqValid, 0);
      MemReqReady = 0;
      // sh formatting
      st(2'b01, 32'h2002, 32'h0000_1234);
      tick();
      StoreValidM = 0;
      chk("sh_addr", MemReqAddr, 32'h2000);
      chk("sh_data", MemReqData, 32'h1234_1234);
      chk("sh_strb", MemReqStrb, 4'b1100);
      MemReqReady = 1;
      tick();
      chk("sh_drained", CountM, 0);
      MemReqReady = 0;
      // misaligned sw
      st(2'b10, 32'h3001, 32'hDEAD_BEEF);
      chk("mis_nostall", StallM2H, 0);
      tick();
      StoreValidM = 0;
      chk("mis_flag", MisalignM2H, 1);
      chk("mis_count", CountM, 0);
      chk("mis_valid", MemReqValid, 0);
      tick();
      chk("mis_oneshot", MisalignM2H, 0);
      // illegal type
      st(2'b11, 32'h3000, 32'h0);
      tick();
      StoreValidM = 0;
      chk("ill_flag", MisalignM2H, 1);
      chk("ill_count", CountM, 0);
      // fill with 4 stores
      for (int i = 0; i < 4; i++) begin
         st(2'b10, 32'h100 + 32'(4 * i), 32'(i + 1));
         tick();
      end
      chk("full_count", CountM, 4);
      st(2'b10, 32'h200, 32'h55);
      chk("full_stall", StallM2H, 1);
      tick();
      chk("full_noenq", CountM, 4);
      // full plus dequeue on same edge: still no enqueue
      MemReqReady = 1;
      chk("fd_head", MemReqAddr, 32'h100);
      chk("fd_hdata", MemReqData, 32'h1);
      tick();
      chk("fd_count", CountM, 3);
      chk("fd_head2", MemReqAddr, 32'h104);
      // simultaneous enqueue and dequeue when not full
      st(2'b10, 32'h300, 32'h77);
      chk("ed_nostall", StallM2H, 0);
      tick();
      StoreValidM = 0;
      chk("ed_count", CountM, 3);
      chk("ord_108", MemReqAddr, 32'h108);
      chk("ord_108d", MemReqData, 32'h3);
      tick();
      chk("ord_10c", MemReqAddr, 32'h10C);
      chk("ord_10cd", MemReqData, 32'h4);
      tick();
      chk("ord_300", MemReqAddr, 32'h300);
      chk("ord_300d", MemReqData, 32'h77);
      tick();
      chk("ord_empty", MemReqValid, 0);
      MemReqReady = 0;
      // load conflict
      st(2'b10, 32'h4008, 32'h99);
      tick();
      StoreValidM = 0;
      LoadValidM  = 1;
      AddrM       = 32'h400A;
      #1 chk("ld_conflict", StallM2H, 1);
      AddrM = 32'h400C;
      #1 chk("ld_noconflict", StallM2H, 0);
      LoadValidM = 0;
      AddrM      = 32'h400A;
      #1 chk("ld_novalid", StallM2H, 0);
      // reset with 3 pending
      st(2'b10, 32'h500, 32'h1);
      tick();
      st(2'b10, 32'h504, 32'h2);
      tick();
      StoreValidM = 0;
      chk("pre_rst_count", CountM, 3);
      #2 reset = 0;
      #1;
      chk("mid_rst_count", CountM, 0);
      chk("mid_rst_valid", MemReqValid, 0);
      chk("mid_rst_strb", MemReqStrb, 0);
      tick();
      reset = 1;
      MemReqReady = 1;
      tick();
      chk("post_rst_valid", MemReqValid, 0);
      MemReqReady = 0;
      // first enqueue right after reset release
      reset = 0;
      tick();
      reset = 1;
      st(2'b00, 32'h0000_0601, 32'h0000_00C3);
      tick();
      StoreValidM = 0;
      chk("first_count", CountM, 1);
      chk("first_strb", MemReqStrb, 4'b0010);
      chk("first_data", MemReqData, 32'hC3C3_C3C3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
